// File: rtl/rle_stream_encoder.sv
// rle_stream_encoder
//   Run-length encoder working in place on a word-wide single-port SRAM. Reads message bytes
//   (little-endian within a word), encodes them as (count, value) byte pairs and writes the packed
//   pairs back to the SRAM, BPW/2 pairs per word, zero-padding the last word.
//
// Parameters
//   DATA_W  : SRAM word width (16, 32 or 64); BPW = DATA_W/8 bytes per word
//   ADDR_W  : SRAM byte-address width (<= 32)
//   MAX_RUN : longest run encoded in one pair (1..255)
//
// Ports
//   clk, nreset                 : clock, asynchronous active-low reset
//   start                       : launch an encode (honoured in idle/done only)
//   message_addr / message_size : source byte address (word-aligned) and length in bytes
//   rle_addr                    : destination byte address (word-aligned)
//   rle_size                    : encoded length in bytes (2 * pairs), excluding pad
//   done                        : encode finished; held until the next start
//   port_A_*                    : SRAM port A (clock, address, write enable, write/read data)
//   run_count, busy_cycles      : pairs emitted / cycles spent working (RLE_STATS_EN only)
//
// Optional feature macro: RLE_STATS_EN adds the run_count and busy_cycles outputs.

module rle_stream_encoder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MAX_RUN = 255
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    input  logic [31:0]       rle_addr,
    output logic [31:0]       rle_size,
    output logic              done,
`ifdef RLE_STATS_EN
    output logic [31:0]       run_count,
    output logic [31:0]       busy_cycles,
`endif
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [DATA_W-1:0] port_A_data_in,
    input  logic [DATA_W-1:0] port_A_data_out
);

    localparam int unsigned BPW   = DATA_W / 8;
    localparam int unsigned PAIRS = BPW / 2;
    localparam int unsigned OFF_W = $clog2(BPW);
    localparam int unsigned PW    = $clog2(PAIRS + 1);

    typedef enum logic [2:0] {
        StIdle, StRdReq, StRdWait, StScan, StWrite, StFlush, StDone
    } state_e;

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;       // state to resume after a buffer write
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]         bytes_left_q, bytes_left_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [OFF_W-1:0]    byte_idx_q, byte_idx_d;
    logic                run_open_q, run_open_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          val_q, val_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [PW-1:0]       pair_idx_q, pair_idx_d;
    logic [31:0]         rle_size_q, rle_size_d;
    logic                done_q, done_d;

    logic                emit;
    logic [7:0]          cur_byte;
    logic                buf_last;
    logic                launch;
    state_e              scan_nxt;

    // Only the address bits inside the SRAM range are meaningful.
    logic                unused_addr;
    assign unused_addr = ^{message_addr, rle_addr};

    assign cur_byte = word_q[{byte_idx_q, 3'b000} +: 8];
    assign buf_last = (pair_idx_q == PW'(PAIRS - 1));
    assign launch   = start && (state_q == StIdle || state_q == StDone);

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        bytes_left_d = bytes_left_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        run_open_d   = run_open_q;
        cnt_d        = cnt_q;
        val_d        = val_q;
        buf_d        = buf_q;
        pair_idx_d   = pair_idx_q;
        rle_size_d   = rle_size_q;
        done_d       = (state_q == StDone) && !start;
        emit         = 1'b0;
        scan_nxt     = StScan;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    rd_ptr_d     = {message_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wr_ptr_d     = {rle_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    bytes_left_d = message_size;
                    rle_size_d   = '0;
                    run_open_d   = 1'b0;
                    buf_d        = '0;
                    pair_idx_d   = '0;
                    byte_idx_d   = '0;
                    state_d      = (message_size == 32'd0) ? StDone : StRdReq;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                word_d     = port_A_data_out;
                rd_ptr_d   = rd_ptr_q + ADDR_W'(BPW);
                byte_idx_d = '0;
                state_d    = StScan;
            end
            StScan: begin
                if (!run_open_q) begin
                    run_open_d = 1'b1;
                    cnt_d      = 8'd1;
                    val_d      = cur_byte;
                end else if (cur_byte == val_q && cnt_q < 8'(MAX_RUN)) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // Close the current run with the old count/value, start a new one.
                    emit  = 1'b1;
                    cnt_d = 8'd1;
                    val_d = cur_byte;
                end
                bytes_left_d = bytes_left_q - 32'd1;
                byte_idx_d   = byte_idx_q + OFF_W'(1);
                if (bytes_left_q == 32'd1) begin
                    scan_nxt = StFlush;
                end else if (byte_idx_q == OFF_W'(BPW - 1)) begin
                    scan_nxt = StRdReq;
                end else begin
                    scan_nxt = StScan;
                end
                if (emit && buf_last) begin
                    ret_d   = scan_nxt;
                    state_d = StWrite;
                end else begin
                    state_d = scan_nxt;
                end
            end
            StFlush: begin
                if (run_open_q) begin
                    // Final pair of the message still lives in cnt/val.
                    emit       = 1'b1;
                    run_open_d = 1'b0;
                    if (buf_last) begin
                        ret_d   = StFlush;
                        state_d = StWrite;
                    end
                end else if (pair_idx_q != '0) begin
                    ret_d   = StDone;
                    state_d = StWrite;
                end else begin
                    state_d = StDone;
                end
            end
            StWrite: begin
                wr_ptr_d   = wr_ptr_q + ADDR_W'(BPW);
                buf_d      = '0;
                pair_idx_d = '0;
                state_d    = ret_q;
            end
            default: state_d = StIdle;
        endcase

        // Emitted pair always carries the run as it stood before this cycle.
        if (emit) begin
            for (int p = 0; p < int'(PAIRS); p++) begin
                if (pair_idx_q == PW'(p)) begin
                    buf_d[16*p +: 16] = {val_q, cnt_q};
                end
            end
            pair_idx_d = pair_idx_q + PW'(1);
            rle_size_d = rle_size_q + 32'd2;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= StIdle;
            ret_q        <= StIdle;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            bytes_left_q <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            run_open_q   <= 1'b0;
            cnt_q        <= '0;
            val_q        <= '0;
            buf_q        <= '0;
            pair_idx_q   <= '0;
            rle_size_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            bytes_left_q <= bytes_left_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            run_open_q   <= run_open_d;
            cnt_q        <= cnt_d;
            val_q        <= val_d;
            buf_q        <= buf_d;
            pair_idx_q   <= pair_idx_d;
            rle_size_q   <= rle_size_d;
            done_q       <= done_d;
        end
    end

`ifdef RLE_STATS_EN
    logic [31:0] run_count_q, busy_cycles_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            run_count_q   <= '0;
            busy_cycles_q <= '0;
        end else if (launch) begin
            run_count_q   <= '0;
            busy_cycles_q <= '0;
        end else if (state_q != StIdle && state_q != StDone) begin
            busy_cycles_q <= busy_cycles_q + 32'd1;
            if (emit) begin
                run_count_q <= run_count_q + 32'd1;
            end
        end
    end

    assign run_count   = run_count_q;
    assign busy_cycles = busy_cycles_q;
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

    assign rle_size       = rle_size_q;
    assign done           = done_q;
    assign port_A_clk     = clk;
    assign port_A_we      = (state_q == StWrite);
    assign port_A_addr    = (state_q == StRdReq) ? rd_ptr_q :
                            (state_q == StWrite) ? wr_ptr_q : '0;
    assign port_A_data_in = (state_q == StWrite) ? buf_q : '0;

endmodule

// File: tb/tb_rle_stream_encoder.sv
// tb_rle_stream_encoder
//   Directed bench for rle_stream_encoder (default parameters). A word memory model serves reads;
//   expected writes are queued by the stimulus and checked by an independent write monitor.
//   Define RLE_STATS_EN to also check run_count.

module tb_rle_stream_encoder;

    localparam logic [31:0] MsgAddr = 32'h0000_0100;
    localparam logic [31:0] RleAddr = 32'h0000_0800;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] message_addr = MsgAddr;
    logic [31:0] message_size = '0;
    logic [31:0] rle_addr = RleAddr;
    logic [31:0] rle_size;
    logic        done;
`ifdef RLE_STATS_EN
    logic [31:0] run_count;
    logic [31:0] busy_cycles;
`endif
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out = '0;

    logic [31:0] mem [0:1023];
    logic [15:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    rle_stream_encoder dut (
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .done            (done),
`ifdef RLE_STATS_EN
        .run_count       (run_count),
        .busy_cycles     (busy_cycles),
`endif
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM model; DUT writes are captured by the monitor only.
    always @(posedge clk) begin
        port_A_data_out <= mem[port_A_addr[11:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nreset && port_A_we) begin
            if (exp_addr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         port_A_addr, port_A_data_in);
            end else begin
                check("write_addr", 64'(port_A_addr), 64'(exp_addr_q.pop_front()));
                check("write_data", 64'(port_A_data_in), 64'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic expect_write(input logic [15:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic pulse_start(input logic [31:0] size);
        @(posedge clk);
        #1;
        message_size = size;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check("done", 64'(done), 64'd1);
    endtask

    task automatic end_of_test(input logic [31:0] exp_size);
        check("rle_size", 64'(rle_size), 64'(exp_size));
        check("writes_outstanding", 64'(exp_addr_q.size()), 64'd0);
    endtask

    task automatic load_test1();
        mem[MsgAddr[11:2]]       = 32'h4141_4141;
        mem[MsgAddr[11:2] + 10'd1] = 32'h4342_4242;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset state
        #12;
        check("rst_done", 64'(done), 64'd0);
        check("rst_rle_size", 64'(rle_size), 64'd0);
        check("rst_we", 64'(port_A_we), 64'd0);
        check("rst_addr", 64'(port_A_addr), 64'd0);
        check("rst_data_in", 64'(port_A_data_in), 64'd0);
        nreset = 1'b1;

        // Test 1: mixed runs across two source words, two output words
        load_test1();
        expect_write(16'h0800, 32'h4203_4104);
        expect_write(16'h0804, 32'h0000_4301);
        pulse_start(32'd8);
        wait_done();
        end_of_test(32'd6);

        // Test 2: 300 zero bytes split at MAX_RUN
        for (int i = 0; i < 75; i++) mem[MsgAddr[11:2] + 10'(i)] = '0;
        expect_write(16'h0800, 32'h002D_00FF);
        pulse_start(32'd300);
        wait_done();
        end_of_test(32'd4);

        // Test 3: bytes past message_size ignored
        mem[MsgAddr[11:2]]         = 32'h1111_1111;
        mem[MsgAddr[11:2] + 10'd1] = 32'hAABB_CC22;
        expect_write(16'h0800, 32'h2201_1104);
        pulse_start(32'd5);
        wait_done();
        end_of_test(32'd4);

        // Test 4: every byte differs -> full buffer at word boundary and in flush
        mem[MsgAddr[11:2]] = 32'h0403_0201;
        expect_write(16'h0800, 32'h0201_0101);
        expect_write(16'h0804, 32'h0401_0301);
        pulse_start(32'd4);
        wait_done();
        end_of_test(32'd8);

        // Test 5: size 0 -> no write, done within 2 cycles, rle_size cleared
        @(posedge clk);
        #1;
        message_size = 32'd0;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("size0_done_drop", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("size0_done", 64'(done), 64'd1);
        end_of_test(32'd0);

        // Test 6: reset during scan aborts, then a clean rerun of test 1
        load_test1();
        pulse_start(32'd8);
        repeat (3) @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("abort_we", 64'(port_A_we), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rle_size", 64'(rle_size), 64'd0);
        @(posedge clk);
        #3;
        nreset = 1'b1;
        expect_write(16'h0800, 32'h4203_4104);
        expect_write(16'h0804, 32'h0000_4301);
        pulse_start(32'd8);
        wait_done();
        end_of_test(32'd6);

        // Test 7: start pulses mid-encode are ignored; done holds afterwards
        expect_write(16'h0800, 32'h4203_4104);
        expect_write(16'h0804, 32'h0000_4301);
        pulse_start(32'd8);
        repeat (3) @(posedge clk);
        #1;
        message_size = 32'd1;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        message_size = 32'd8;
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        check("done_held", 64'(done), 64'd1);
        end_of_test(32'd6);
`ifdef RLE_STATS_EN
        check("run_count", 64'(run_count), 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
